mc_cpu: RTL

Parametrised multicycle successor to the single-cycle 16-bit core. It uses a fixed 16-bit instruction word, a configurable datapath width and a configurable PC width. It has an FSM-sequenced fetch/decode/execute/memory/writeback flow. Instruction and data memories are external, each behind a req/ack handshake, so memories with variable latency can be attached. It sits at top level under the SoC wrapper and replaces the single-cycle cpu.

---
 rtl/mc_cpu_if.sv | 27 ++
 rtl/mc_cpu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mc_cpu_if.sv
// Instruction and data memory request/acknowledge bus of the multicycle core.
// The core is the master; memories with any latency attach on the slave side.
interface mc_cpu_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_rdata;
  logic              imem_ack;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mc_cpu.sv
// Multicycle 16-bit-instruction core: FETCH/DECODE/EXEC/MEM/WB sequencing with
// req/ack instruction and data memories; HALT or an undefined opcode stops it.
module mc_cpu #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int NREGS  = 8
) (
  input  logic            clk,
  input  logic            reset,
  mc_cpu_if.master        bus,
  output logic            retire,
  output logic            halted,
  output logic            illegal,
  output logic [PC_W-1:0] pc_dbg
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, STOP} state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, y_q, y_d;
  logic              halted_q, halted_d, illegal_q, illegal_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [3:0]        opcode;
  logic [2:0]        rs1, rt, rd, wb_reg;
  logic [DATA_W-1:0] rs1_val, rt_val, imm_ext, alu_y;
  logic [PC_W-1:0]   pc_inc, pc_branch, imm_pc;

  assign opcode    = ir_q[15:12];
  assign rs1       = ir_q[11:9];
  assign rt        = ir_q[8:6];
  assign rd        = ir_q[5:3];
  assign wb_reg    = (opcode <= OP_NOT) ? rd : rt;
  assign rs1_val   = (rs1 == 3'd0) ? '0 : regs_q[rs1];
  assign rt_val    = (rt == 3'd0) ? '0 : regs_q[rt];
  assign imm_ext   = DATA_W'($signed(ir_q[5:0]));
  assign imm_pc    = PC_W'($signed(ir_q[5:0]));
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_branch = pc_inc + imm_pc;

  assign bus.imem_addr  = pc_q;
  assign bus.dmem_addr  = y_q;
  assign bus.dmem_wdata = b_q;
  assign halted         = halted_q;
  assign illegal        = illegal_q;
  assign pc_dbg         = pc_q;

  // LW, SW and ADDI all fall through to the address/immediate sum
  always_comb begin
    alu_y = a_q + imm_q;
    case (opcode)
      OP_ADD:  alu_y = a_q + b_q;
      OP_SUB:  alu_y = a_q - b_q;
      OP_AND:  alu_y = a_q & b_q;
      OP_OR:   alu_y = a_q | b_q;
      OP_NOT:  alu_y = ~a_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    y_d       = y_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    retire       = 1'b0;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;

    case (state_q)
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d   = rs1_val;
        b_d   = rt_val;
        imm_d = imm_ext;
        if (opcode inside {[4'hA:4'hE]}) begin
          illegal_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = STOP;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        y_d = alu_y;
        case (opcode)
          OP_BEQ: begin
            pc_d    = (a_q == b_q) ? pc_branch : pc_inc;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_JMP: begin
            pc_d    = ir_q[PC_W-1:0];
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            retire   = 1'b1;
            state_d  = STOP;
          end
          OP_LW, OP_SW: state_d = MEM;
          default:      state_d = WB;
        endcase
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (opcode == OP_SW);
        if (bus.dmem_ack) begin
          if (opcode == OP_SW) begin
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            y_d     = bus.dmem_rdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        if (wb_reg != 3'd0) regs_d[wb_reg] = y_q;
        pc_d    = pc_inc;
        retire  = 1'b1;
        state_d = FETCH;
      end
      STOP:    ;
      default: state_d = FETCH;
    endcase

    // An access in flight when reset arrives is abandoned immediately
    if (reset) begin
      retire       = 1'b0;
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      y_q       <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      y_q       <= y_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end
endmodule
